uplink_tx_gearbox: RTL and testbench

//  Downstream of the uplink interleaver: takes one 256-bit interleaved uplink frame per frame period and

---
 rtl/uplink_pkg.sv | 28 ++
 rtl/uplink_prbs7_gen.sv | 40 ++++
 rtl/uplink_tx_gearbox.sv | 194 +++++++++++++++++++
 tb/tb_uplink_tx_gearbox.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uplink_pkg.sv
// Shared types and constants for the uplink transmit gearbox.
// Optional feature macro used by the gearbox: UPLINK_GBX_PRBS_EN.
package uplink_pkg;

    localparam int FRAME_W      = 256;
    localparam int HALF_FRAME_W = 128;

    localparam logic TX_RATE_5G12  = 1'b0;
    localparam logic TX_RATE_10G24 = 1'b1;

    localparam logic [1:0] HEADER = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gbx_state_e;

    // Left-justify the active part of a frame so emission always starts at bit FRAME_W-1.
    // At 5.12G only frame[127:0] is active; the upper half is discarded here.
    function automatic logic [FRAME_W-1:0] align_frame(input logic [FRAME_W-1:0] frame,
                                                       input logic               rate);
        if (rate == TX_RATE_10G24) begin
            return frame;
        end
        return {frame[HALF_FRAME_W-1:0], {HALF_FRAME_W{1'b0}}};
    endfunction

endpackage

// File: rtl/uplink_prbs7_gen.sv
// WORD_W-parallel PRBS7 (x^7 + x^6 + 1) generator, MSB of the word is the oldest bit.
// Each generated bit is s[6]^s[5]; that bit is shifted into s[0].
module uplink_prbs7_gen #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reseed_i,
    input  logic              advance_i,
    output logic [WORD_W-1:0] word_o
);

    localparam logic [6:0] PRBS_SEED = 7'h7F;

    logic [6:0]        lfsr_q;
    logic [6:0]        lfsr_d;
    logic [WORD_W-1:0] word_d;

    // Unroll WORD_W serial steps to produce the current word and the state after it.
    always_comb begin
        lfsr_d = lfsr_q;
        word_d = '0;
        for (int i = 0; i < WORD_W; i++) begin
            word_d[WORD_W-1-i] = lfsr_d[6] ^ lfsr_d[5];
            lfsr_d             = {lfsr_d[5:0], lfsr_d[6] ^ lfsr_d[5]};
        end
    end

    assign word_o = word_d;

    // LFSR state: reseeded whenever the generator is idle, stepped one word per active cycle.
    always_ff @(posedge clk) begin
        if (rst || reseed_i) begin
            lfsr_q <= PRBS_SEED;
        end else if (advance_i) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/uplink_tx_gearbox.sv
// Uplink transmit gearbox: serialises 128/256-bit interleaved frames into WORD_W-bit words,
// MSB first, with one holding register between frame arrival and emission.
// Optional macro UPLINK_GBX_PRBS_EN adds test_mode_i and a PRBS7 test pattern on word_o.
module uplink_tx_gearbox
    import uplink_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               tx_data_rate_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               frame_valid_i,
    input  logic               clear_flags_i,
`ifdef UPLINK_GBX_PRBS_EN
    input  logic               test_mode_i,
`endif
    output logic [WORD_W-1:0]  word_o,
    output logic               word_valid_o,
    output logic               frame_start_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    // Counter wide enough for 256/8 = 32 words per frame.
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] WPF_FULL_M1 = CNT_W'(FRAME_W / WORD_W - 1);
    localparam logic [CNT_W-1:0] WPF_HALF_M1 = CNT_W'(HALF_FRAME_W / WORD_W - 1);

    if (!(WORD_W == 8 || WORD_W == 16 || WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
        $error("uplink_tx_gearbox: WORD_W must be 8, 16, 32 or 64");
    end

    gbx_state_e         state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rate_q, rate_d;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic               hold_valid_q, hold_valid_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               test_mode_w;
    logic [CNT_W-1:0]   wpf_m1;
    logic               at_boundary;

`ifdef UPLINK_GBX_PRBS_EN
    logic               test_mode_q;
    logic [WORD_W-1:0]  prbs_word;

    assign test_mode_w = test_mode_i;

    // Registered test-mode so PRBS output starts cleanly from the seed one cycle after entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            test_mode_q <= 1'b0;
        end else begin
            test_mode_q <= test_mode_i;
        end
    end

    uplink_prbs7_gen #(
        .WORD_W (WORD_W)
    ) u_prbs (
        .clk       (clk),
        .rst       (rst),
        .reseed_i  (~test_mode_q),
        .advance_i (test_mode_q),
        .word_o    (prbs_word)
    );
`else
    assign test_mode_w = 1'b0;
`endif

    // Words-per-frame follows the rate latched when the current frame was loaded.
    assign wpf_m1      = (rate_q == TX_RATE_10G24) ? WPF_FULL_M1 : WPF_HALF_M1;
    assign at_boundary = (cnt_q == wpf_m1);

    // Next-state logic: frame loading, word shifting, holding register and sticky flags.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        rate_d       = rate_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        overflow_d   = overflow_q & ~clear_flags_i;
        underflow_d  = underflow_q & ~clear_flags_i;

        if (test_mode_w || !en_i) begin
            // Flush: frames ignored, nothing held, flags keep their value.
            state_d      = IDLE;
            shift_d      = '0;
            cnt_d        = '0;
            hold_d       = '0;
            hold_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_valid_i) begin
                        shift_d = align_frame(frame_i, tx_data_rate_i);
                        rate_d  = tx_data_rate_i;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (at_boundary) begin
                        cnt_d = '0;
                        if (hold_valid_q) begin
                            // Held frame goes out next; a frame arriving now refills the holder.
                            shift_d = align_frame(hold_q, tx_data_rate_i);
                            rate_d  = tx_data_rate_i;
                            if (frame_valid_i) begin
                                hold_d = frame_i;
                            end else begin
                                hold_valid_d = 1'b0;
                            end
                        end else if (frame_valid_i) begin
                            // Bypass straight into the shifter, no gap cycle.
                            shift_d = align_frame(frame_i, tx_data_rate_i);
                            rate_d  = tx_data_rate_i;
                        end else begin
                            underflow_d = 1'b1;
                            shift_d     = '0;
                            state_d     = IDLE;
                        end
                    end else begin
                        shift_d = shift_q << WORD_W;
                        cnt_d   = cnt_q + 1'b1;
                        if (frame_valid_i) begin
                            if (!hold_valid_q) begin
                                hold_d       = frame_i;
                                hold_valid_d = 1'b1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            rate_q       <= TX_RATE_5G12;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            rate_q       <= rate_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        word_o        = '0;
        word_valid_o  = 1'b0;
        frame_start_o = 1'b0;
        if (state_q == RUN) begin
            word_o        = shift_q[FRAME_W-1 -: WORD_W];
            word_valid_o  = 1'b1;
            frame_start_o = (cnt_q == '0);
        end
`ifdef UPLINK_GBX_PRBS_EN
        if (test_mode_q) begin
            word_o        = prbs_word;
            word_valid_o  = 1'b1;
            frame_start_o = 1'b0;
        end
`endif
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_uplink_tx_gearbox.sv
// Directed self-checking bench for uplink_tx_gearbox (WORD_W=32).
// The PRBS scenario is compiled only when UPLINK_GBX_PRBS_EN is defined.
module tb_uplink_tx_gearbox;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         rate;
    logic [255:0] frame;
    logic         fv;
    logic         clr;
    logic         tm;
    logic [31:0]  word;
    logic         wvalid;
    logic         fstart;
    logic         ovf;
    logic         unf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uplink_tx_gearbox #(.WORD_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en),
        .tx_data_rate_i (rate),
        .frame_i        (frame),
        .frame_valid_i  (fv),
        .clear_flags_i  (clr),
`ifdef UPLINK_GBX_PRBS_EN
        .test_mode_i    (tm),
`endif
        .word_o         (word),
        .word_valid_o   (wvalid),
        .frame_start_o  (fstart),
        .overflow_o     (ovf),
        .underflow_o    (unf)
    );

    // Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wv(input int n, input int j);
        return 32'h8A5A_0000 | 32'(n << 8) | 32'(j);
    endfunction

    // wide=1: 8 words in frame[255:0]; wide=0: 4 words in frame[127:0], upper half all ones.
    function automatic logic [255:0] mk_frame(input int n, input bit wide);
        logic [255:0] f;
        f = '0;
        if (wide) begin
            for (int j = 0; j < 8; j++) f[255 - 32*j -: 32] = wv(n, j);
        end else begin
            f[255:128] = '1;
            for (int j = 0; j < 4; j++) f[127 - 32*j -: 32] = wv(n, j);
        end
        return f;
    endfunction

    task automatic clear_flags();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; rate = 1'b1; fv = 1'b0; clr = 1'b0; tm = 1'b0; frame = '0;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if (word !== 32'h0) begin errors++; $display("FAIL reset_word: got %h expected 0", word); end
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", wvalid); end
        checks++; if (fstart !== 1'b0) begin errors++; $display("FAIL reset_fstart: got %b expected 0", fstart); end
        checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {ovf, unf}); end
        // reset in the middle of a frame returns everything to zero
        fv = 1'b1; frame = mk_frame(1, 1'b1); tick(); fv = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if ({wvalid, word} !== 33'h0) begin errors++; $display("FAIL reset_midrun: got valid=%b word=%h expected 0/0", wvalid, word); end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        logic [255:0] f;
        logic [31:0]  exp;
        f = '0; f[255] = 1'b1; f[0] = 1'b1;
        rate = 1'b1; fv = 1'b1; frame = f; tick(); fv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp = (k == 0) ? 32'h8000_0000 : ((k == 7) ? 32'h0000_0001 : 32'h0);
            checks++; if (word !== exp) begin errors++; $display("FAIL single_word%0d: got %h expected %h", k, word, exp); end
            checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL single_valid%0d: got %b expected 1", k, wvalid); end
            checks++; if (fstart !== (k == 0)) begin errors++; $display("FAIL single_fstart%0d: got %b expected %b", k, fstart, (k == 0)); end
            tick();
        end
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL single_idle: got valid %b expected 0", wvalid); end
        checks++; if (unf !== 1'b1) begin errors++; $display("FAIL single_underflow: got %b expected 1", unf); end
        $display("test_single_frame done");
    endtask

    task automatic test_back_to_back_5g();
        clear_flags();
        rate = 1'b0; fv = 1'b1; frame = mk_frame(0, 1'b0); tick(); fv = 1'b0;
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 4; j++) begin
                checks++; if (word !== wv(n, j) || wvalid !== 1'b1) begin errors++; $display("FAIL b2b_word f%0d w%0d: got %h v=%b expected %h v=1", n, j, word, wvalid, wv(n, j)); end
                checks++; if (fstart !== (j == 0)) begin errors++; $display("FAIL b2b_fstart f%0d w%0d: got %b expected %b", n, j, fstart, (j == 0)); end
                if (n == 3 && j == 3) begin
                    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL b2b_flags: got %b expected 00", {ovf, unf}); end
                end
                if (j == 3 && n < 3) begin fv = 1'b1; frame = mk_frame(n + 1, 1'b0); end
                else fv = 1'b0;
                tick();
            end
        end
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b expected 0", wvalid); end
        $display("test_back_to_back_5g done");
    endtask

    task automatic test_overflow();
        int n;
        int j;
        clear_flags();
        rate = 1'b1; fv = 1'b1; frame = mk_frame(10, 1'b1); tick(); fv = 1'b0;
        for (int idx = 0; idx < 16; idx++) begin
            n = 10 + idx / 8; j = idx % 8;
            checks++; if (word !== wv(n, j) || wvalid !== 1'b1) begin errors++; $display("FAIL ovf_word f%0d w%0d: got %h v=%b expected %h v=1", n, j, word, wvalid, wv(n, j)); end
            if (idx == 3) begin
                checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", ovf); end
            end
            if (idx == 4) begin
                checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
            end
            if (idx == 1) begin fv = 1'b1; frame = mk_frame(11, 1'b1); end
            else if (idx == 3) begin fv = 1'b1; frame = mk_frame(12, 1'b1); end
            else fv = 1'b0;
            tick();
        end
        checks++; if ({wvalid, ovf, unf} !== 3'b011) begin errors++; $display("FAIL ovf_end: got v/ovf/unf=%b expected 011", {wvalid, ovf, unf}); end
        $display("test_overflow done");
    endtask

    task automatic test_rate_switch();
        int n;
        int j;
        clear_flags();
        checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL rate_clear: got %b expected 00", {ovf, unf}); end
        rate = 1'b1; fv = 1'b1; frame = mk_frame(20, 1'b1); tick(); fv = 1'b0;
        for (int idx = 0; idx < 12; idx++) begin
            n = (idx < 8) ? 20 : 21; j = (idx < 8) ? idx : idx - 8;
            checks++; if (word !== wv(n, j) || wvalid !== 1'b1) begin errors++; $display("FAIL rate_word f%0d w%0d: got %h v=%b expected %h v=1", n, j, word, wvalid, wv(n, j)); end
            checks++; if (fstart !== (j == 0)) begin errors++; $display("FAIL rate_fstart f%0d w%0d: got %b expected %b", n, j, fstart, (j == 0)); end
            if (idx == 2) rate = 1'b0;
            if (idx == 7) begin fv = 1'b1; frame = mk_frame(21, 1'b0); end
            else fv = 1'b0;
            tick();
        end
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL rate_end_valid: got %b expected 0", wvalid); end
        $display("test_rate_switch done");
    endtask

    task automatic test_flush();
        // underflow is still set from the previous scenario and must survive the flush
        rate = 1'b1; fv = 1'b1; frame = mk_frame(30, 1'b1); tick(); fv = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checks++; if (word !== wv(30, j)) begin errors++; $display("FAIL flush_word%0d: got %h expected %h", j, word, wv(30, j)); end
            if (j == 1) begin fv = 1'b1; frame = mk_frame(31, 1'b1); end
            else fv = 1'b0;
            if (j == 3) en = 1'b0;
            tick();
        end
        checks++; if ({wvalid, fstart, word} !== 34'h0) begin errors++; $display("FAIL flush_out: got v=%b fs=%b word=%h expected 0", wvalid, fstart, word); end
        checks++; if ({ovf, unf} !== 2'b01) begin errors++; $display("FAIL flush_flags: got %b expected 01", {ovf, unf}); end
        en = 1'b1; tick();
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL flush_reen_valid: got %b expected 0", wvalid); end
        fv = 1'b1; frame = mk_frame(32, 1'b1); tick(); fv = 1'b0;
        for (int j = 0; j < 8; j++) begin
            checks++; if (word !== wv(32, j) || fstart !== (j == 0)) begin errors++; $display("FAIL flush_new w%0d: got %h fs=%b expected %h fs=%b", j, word, fstart, wv(32, j), (j == 0)); end
            tick();
        end
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL flush_hold_cleared: got valid %b expected 0", wvalid); end
        $display("test_flush done");
    endtask

    task automatic test_flag_priority();
        clear_flags();
        rate = 1'b0; fv = 1'b1; frame = mk_frame(40, 1'b0); tick(); fv = 1'b0;
        tick(); tick(); tick();
        clr = 1'b1; tick(); clr = 1'b0;
        checks++; if (unf !== 1'b1) begin errors++; $display("FAIL prio_set_wins: got %b expected 1", unf); end
        clear_flags();
        checks++; if (unf !== 1'b0) begin errors++; $display("FAIL prio_clear: got %b expected 0", unf); end
        $display("test_flag_priority done");
    endtask

`ifdef UPLINK_GBX_PRBS_EN
    task automatic test_prbs();
        bit          y [0:299];
        logic [31:0] exp;
        for (int i = 0; i < 7; i++) y[i] = 1'b1;
        for (int i = 7; i < 300; i++) y[i] = y[i-7] ^ y[i-6];
        clear_flags();
        tm = 1'b1; tick();
        for (int w = 0; w < 8; w++) begin
            for (int b = 0; b < 32; b++) exp[31-b] = y[7 + 32*w + b];
            checks++; if (word !== exp || wvalid !== 1'b1 || fstart !== 1'b0) begin errors++; $display("FAIL prbs_word%0d: got %h v=%b fs=%b expected %h v=1 fs=0", w, word, wvalid, fstart, exp); end
            if (w == 2) begin fv = 1'b1; frame = mk_frame(50, 1'b1); end
            else fv = 1'b0;
            tick();
        end
        checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL prbs_flags: got %b expected 00", {ovf, unf}); end
        tm = 1'b0; tick();
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL prbs_exit: got valid %b expected 0", wvalid); end
        tm = 1'b1; tick();
        for (int b = 0; b < 32; b++) exp[31-b] = y[7 + b];
        checks++; if (word !== exp) begin errors++; $display("FAIL prbs_reseed: got %h expected %h", word, exp); end
        tm = 1'b0; tick();
        $display("test_prbs done");
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back_5g();
        test_overflow();
        test_rate_switch();
        test_flush();
        test_flag_priority();
`ifdef UPLINK_GBX_PRBS_EN
        test_prbs();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
